ps2_key_decoder: RTL and testbench
==================================

Name: ps2_key_decoder

Overview:
- Receives raw PS/2 keyboard serial traffic (device-to-host) and produces the 11-bit `ps2_key` event word consumed by the core's input logic: {toggle, pressed, extended, code}.
- It is the producing end of that interface, and the core can use it for native keyboard attachment without an hps_io key path.
- It sits in the clk_sys domain beside hps_io. Its output drops directly onto the existing `ps2_key` wire.

Parameters:
- FILTER_LEN, 8: consecutive identical clk_sys samples required before the filtered ps2_clk/ps2_data level changes.
- TIMEOUT, 24000: clk_sys cycles without a falling ps2_clk edge, mid-frame, before the frame is aborted (about 1 ms).

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- ps2_key  out  11  [10] toggles once per key event; [9] 1=make, 0=break; [8] E0-extended; [7:0] scancode.
- key_strobe  out  1  one-cycle pulse in the same cycle ps2_key updates.
- frame_err  out  1  one-cycle pulse on a parity, start, stop or timeout error.

Behaviour:
- Reset: ps2_key=0, key_strobe=0, frame_err=0, all flags cleared, receiver IDLE, E1 skip count 0, both filtered lines=1.
- Input conditioning:
  - 2-flop synchronizer per line.
  - Saturating counter per line, width ceil(log2(FILTER_LEN+1)). The filtered level flips only after FILTER_LEN consecutive samples that differ from the current level.
  - A bit is sampled on a falling edge of filtered ps2_clk, using filtered ps2_data on that same cycle.
- Receiver FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on an edge with data=0 (start bit), go to DATA with bit count 0. On an edge with data=1, set frame_err and stay IDLE.
  - DATA: shift in LSB first. After the 8th bit, go to PARITY.
  - PARITY: the XOR of the 8 data bits and the parity bit must be 1 (odd parity). Latch the result and go to STOP.
  - STOP: data must be 1. On good parity and stop, present the byte to the decoder for one cycle. Otherwise pulse frame_err and discard the byte. Return to IDLE either way.
  - Timeout: an idle counter resets on every falling edge. If it reaches TIMEOUT in any state other than IDLE, abort to IDLE and pulse frame_err. The counter saturates and never wraps.
- Byte decoder (acts the cycle after STOP accepts the byte):
  - skip count > 0: decrement it; nothing else changes.
  - 0xE1: set skip count = 7 (rest of the Pause sequence); no event emitted.
  - 0xE0: set ext flag.
  - 0xF0: set rel flag.
  - Any other byte:
    - Emit ps2_key <= {~ps2_key[10], ~rel, ext, byte} and pulse key_strobe.
    - Clear ext and rel.
- Error handling: any frame_err also clears ext, rel and the skip count, so a dropped prefix cannot corrupt the next key.
- Latency: key_strobe is asserted exactly 2 clk_sys cycles after the filtered falling edge that samples the stop bit (STOP acceptance, then decode). Filter delay adds FILTER_LEN+2 cycles from the raw pin.
- ps2_key holds its value between events. Bit 10 is the only change indicator and has no ack/back-pressure.
- RESET asserted mid-frame discards the partial frame; no strobe or error is produced.

Test Plan:
- Make key: frame 0x1C (A), parity 0 → ps2_key=0x61C ([10]=1, [9]=1, [8]=0), key_strobe high 1 cycle, frame_err=0.
- Break, extended: bytes E0, F0, 75 → exactly one strobe, ps2_key={~prev[10],0,1,0x75}. No strobe on the prefix bytes.
- Parity error: frame 0x29 with parity 1 (even) → frame_err pulse, ps2_key unchanged. The next good 0x29 yields ps2_key[7:0]=0x29, [8]=0.
- Timeout: send start plus 4 bits, then hold ps2_clk high for 24000 cycles → frame_err pulse, FSM IDLE. The following full 0x16 frame decodes correctly.
- Pause: bytes E1 14 77 E1 F0 14 F0 77 → zero strobes and skip count back to 0. A subsequent 0x05 emits ps2_key[7:0]=0x05, [9]=1.
- Glitch and reset: a 3-cycle low pulse on ps2_clk causes no bit sampling. Assert RESET after the 5th data bit → all outputs 0. The next full frame decodes normally.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Key event bus between the PS/2 keyboard decoder (master) and the core input logic (slave).
interface ps2_key_decoder_if;
  logic [10:0] ps2_key;
  logic        key_strobe;
  logic        frame_err;

  modport master (output ps2_key, output key_strobe, output frame_err);
  modport slave  (input  ps2_key, input  key_strobe, input  frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 device-to-host receiver and scancode decoder producing the 11-bit ps2_key event word.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 24000
) (
  input  logic               clk_sys,
  input  logic               RESET,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_decoder_if.master  key_bus
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0] raw_lines;
  logic [1:0] filt_lines;
  assign raw_lines = {ps2_data, ps2_clk};

  // Line 0 is ps2_clk, line 1 is ps2_data; both get identical conditioning so they stay aligned.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic          sync0_reg;
      logic          sync1_reg;
      logic          filt_reg;
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
          sync0_reg <= 1'b1;
          sync1_reg <= 1'b1;
          filt_reg  <= 1'b1;
          cnt_reg   <= '0;
        end else begin
          sync0_reg <= raw_lines[gi];
          sync1_reg <= sync0_reg;
          if (sync1_reg != filt_reg) begin
            if (cnt_reg == CW'(FILTER_LEN - 1)) begin
              filt_reg <= sync1_reg;
              cnt_reg  <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign filt_lines[gi] = filt_reg;
    end
  endgenerate

  logic clk_prev_reg;
  logic fall;
  logic data_bit;
  assign fall     = clk_prev_reg & ~filt_lines[0];
  assign data_bit = filt_lines[1];

  state_t        state_reg, state_next;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          parity_ok_reg;
  logic [TW-1:0] idle_cnt_reg;
  logic [7:0]    rx_byte_reg;
  logic          byte_valid_reg, byte_valid_next;
  logic          frame_err_reg, frame_err_next;
  logic          timeout;

  assign timeout = (state_reg != S_IDLE) && (idle_cnt_reg == TW'(TIMEOUT));

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (timeout) begin
      state_next = S_IDLE;
    end else if (fall) begin
      case (state_reg)
        S_IDLE:   if (!data_bit) state_next = S_DATA;
        S_DATA:   if (bit_cnt_reg == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_err_next  = 1'b0;
    byte_valid_next = 1'b0;
    if (timeout) begin
      frame_err_next = 1'b1;
    end else if (fall) begin
      if (state_reg == S_IDLE && data_bit) begin
        frame_err_next = 1'b1;
      end else if (state_reg == S_STOP) begin
        byte_valid_next = parity_ok_reg & data_bit;
        frame_err_next  = ~(parity_ok_reg & data_bit);
      end
    end
  end

  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      clk_prev_reg   <= 1'b1;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      parity_ok_reg  <= 1'b0;
      idle_cnt_reg   <= '0;
      rx_byte_reg    <= '0;
      byte_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      clk_prev_reg <= filt_lines[0];
      // Saturates so a long idle gap can never wrap back into a false abort window.
      if (fall) begin
        idle_cnt_reg <= '0;
      end else if (idle_cnt_reg != TW'(TIMEOUT)) begin
        idle_cnt_reg <= idle_cnt_reg + 1'b1;
      end
      if (fall && !timeout) begin
        case (state_reg)
          S_IDLE:   bit_cnt_reg <= '0;
          S_DATA: begin
            shift_reg   <= {data_bit, shift_reg[7:1]};
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
          S_PARITY: parity_ok_reg <= ^{shift_reg, data_bit};
          default:  ;
        endcase
      end
      if (byte_valid_next) begin
        rx_byte_reg <= shift_reg;
      end
      byte_valid_reg <= byte_valid_next;
      frame_err_reg  <= frame_err_next;
    end
  end

  logic [10:0] ps2_key_reg;
  logic        key_strobe_reg;
  logic        ext_reg;
  logic        rel_reg;
  logic [2:0]  skip_cnt_reg;

  // An error wipes pending prefixes so a lost E0/F0/E1 cannot bleed into the next key.
  always_ff @(posedge clk_sys or posedge RESET) begin
    if (RESET) begin
      ps2_key_reg    <= '0;
      key_strobe_reg <= 1'b0;
      ext_reg        <= 1'b0;
      rel_reg        <= 1'b0;
      skip_cnt_reg   <= '0;
    end else begin
      key_strobe_reg <= 1'b0;
      if (frame_err_reg) begin
        ext_reg      <= 1'b0;
        rel_reg      <= 1'b0;
        skip_cnt_reg <= '0;
      end else if (byte_valid_reg) begin
        if (skip_cnt_reg != 3'd0) begin
          skip_cnt_reg <= skip_cnt_reg - 1'b1;
        end else begin
          case (rx_byte_reg)
            8'hE1: skip_cnt_reg <= 3'd7;
            8'hE0: ext_reg <= 1'b1;
            8'hF0: rel_reg <= 1'b1;
            default: begin
              ps2_key_reg    <= {~ps2_key_reg[10], ~rel_reg, ext_reg, rx_byte_reg};
              key_strobe_reg <= 1'b1;
              ext_reg        <= 1'b0;
              rel_reg        <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign key_bus.ps2_key    = ps2_key_reg;
  assign key_bus.key_strobe = key_strobe_reg;
  assign key_bus.frame_err  = frame_err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Drives PS/2 frames on the raw pins and compares decoded events against a byte-level keyboard model.
module tb_ps2_key_decoder;

  localparam int FILT = 8;
  localparam int TOUT = 24000;
  localparam int HALF = 20;

  logic clk_sys = 1'b0;
  logic RESET   = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  ps2_key_decoder_if key_bus ();

  ps2_key_decoder #(.FILTER_LEN(FILT), .TIMEOUT(TOUT)) dut (
    .clk_sys  (clk_sys),
    .RESET    (RESET),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .key_bus  (key_bus)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int last_lat = 0;

  // Model state: expected key word, pending prefixes, pause skip, event/error totals.
  logic [10:0] exp_key = '0;
  logic        m_ext = 1'b0;
  logic        m_rel = 1'b0;
  int          m_skip = 0;
  int          exp_strobes = 0;
  int          exp_errs = 0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!RESET) begin
      if (key_bus.key_strobe) begin
        strobe_cnt <= strobe_cnt + 1;
        last_lat   <= cyc - stop_cyc;
      end
      if (key_bus.frame_err) err_cnt <= err_cnt + 1;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_raw(input logic [10:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      wait_cyc(HALF);
      ps2_clk = 1'b0;
      if (i == 10) stop_cyc = cyc;
      wait_cyc(HALF);
      ps2_clk = 1'b1;
    end
    wait_cyc(HALF);
    ps2_data = 1'b1;
  endtask

  function automatic logic model_byte(input logic [7:0] b);
    logic emitted = 1'b0;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE1) begin
      m_skip = 7;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_rel = 1'b1;
    end else begin
      exp_key = {~exp_key[10], ~m_rel, m_ext, b};
      exp_strobes++;
      m_ext = 1'b0;
      m_rel = 1'b0;
      emitted = 1'b1;
    end
    return emitted;
  endfunction

  task automatic model_err();
    exp_errs++;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
  endtask

  task automatic check_state(input string tag);
    check_val({tag, " strobes"}, strobe_cnt, exp_strobes);
    check_val({tag, " errors"}, err_cnt, exp_errs);
    check_val({tag, " key"}, {21'd0, key_bus.ps2_key}, {21'd0, exp_key});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic par;
    logic stp;
    logic emitted;
    par = ~(^b) ^ bad_par;
    stp = ~bad_stop;
    send_raw({stp, par, b, 1'b0}, 11);
    wait_cyc(10);
    if (bad_par || bad_stop) begin
      model_err();
      emitted = 1'b0;
    end else begin
      emitted = model_byte(b);
    end
    check_state($sformatf("byte %02h", b));
    if (emitted) check_val("latency", last_lat, FILT + 4);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] pause_seq [8];
    int r;
    int k;
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    wait_cyc(5);
    check_val("reset key", {21'd0, key_bus.ps2_key}, 32'd0);
    check_val("reset strobe", {31'd0, key_bus.key_strobe}, 32'd0);
    check_val("reset err", {31'd0, key_bus.frame_err}, 32'd0);
    RESET = 1'b0;
    wait_cyc(5);

    send_byte(8'h1C, 1'b0, 1'b0);
    check_val("make A", {21'd0, key_bus.ps2_key}, 32'h61C);

    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);

    send_byte(8'h29, 1'b1, 1'b0);
    send_byte(8'h29, 1'b0, 1'b0);

    foreach (pause_seq[i]) send_byte(pause_seq[i], 1'b0, 1'b0);
    check_val("pause skip", m_skip, 0);
    send_byte(8'h05, 1'b0, 1'b0);

    // Start bit plus four data bits, then silence until the receiver gives up.
    send_raw({1'b1, 1'b0, 8'h16, 1'b0}, 5);
    wait_cyc(TOUT + 100);
    model_err();
    check_state("timeout");
    send_byte(8'h16, 1'b0, 1'b0);

    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(40);
    check_state("glitch");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 15);
      if (r < 2) b = 8'hE0;
      else if (r == 2) b = 8'hF0;
      else if (r == 3) b = 8'hE1;
      else b = 8'($urandom_range(0, 255));
      k = $urandom_range(0, 9);
      send_byte(b, k == 0, k == 1);
    end

    // Abort a frame after its fifth data bit with reset.
    send_raw({1'b1, 1'b0, 8'h3A, 1'b0}, 6);
    RESET = 1'b1;
    wait_cyc(3);
    check_val("midreset key", {21'd0, key_bus.ps2_key}, 32'd0);
    check_val("midreset strobe", {31'd0, key_bus.key_strobe}, 32'd0);
    check_val("midreset err", {31'd0, key_bus.frame_err}, 32'd0);
    RESET = 1'b0;
    exp_key = '0;
    m_ext = 1'b0;
    m_rel = 1'b0;
    m_skip = 0;
    wait_cyc(5);
    send_byte(8'h3A, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
